eeprom_param: RTL and testbench
===============================

# eeprom_param

Parametrised successor to the team's fixed 16×32 EEPROM model: a single-port non-volatile storage block with configurable data width and depth. It adds realistic multi-cycle program timing, bulk erase, write protection, and registered reads with a valid strobe. It sits behind the VDP configuration path and holds palette, mode and timing words loaded at boot.

## Interface
- DATA_W, 32, data word width in bits
- DEPTH, 16, number of words (need not be a power of two; ≥2)
- ADDR_W, $clog2(DEPTH), address width
- WR_CYCLES, 4, program duration in clocks (≥1)
- c  input  1  clock, all logic on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- str  input  1  store request, sampled each edge
- ld  input  1  load (read) request, sampled each edge
- a  input  ADDR_W  word address for str/ld
- d_in  input  DATA_W  write data for str
- wp  input  1  write protect; when 1, str and erase are rejected
- erase  input  1  bulk-erase request
- d  output  DATA_W  registered read data
- d_vld  output  1  one-cycle strobe, d valid
- busy  output  1  program or erase in progress
- err  output  1  one-cycle strobe, request rejected

## Operation
- FSM states: IDLE, PROG, ERASE.
- IDLE + str, wp=0, a<DEPTH: latch a/d_in; counter = WR_CYCLES-1; go to PROG.
- PROG: counter decrements each cycle. At counter==0, write the latched word to the array and return to IDLE.
- IDLE + erase, wp=0: counter = 0 (address index); go to ERASE. Each cycle writes all-ones (erased value) to array[counter] and increments. After index DEPTH-1 is written, return to IDLE.
- ld with a<DEPTH is accepted in any state. d ← array[a] and d_vld=1 on the next edge.
- ld with a≥DEPTH returns d=0 with d_vld=1, and pulses err.
- Reads in PROG/ERASE return the array's current contents. The location under program keeps its old data until commit.
- err pulses for one cycle, on the edge after sampling, when any of these occurs:
  - str or erase arrives while busy;
  - str or erase arrives with wp=1;
  - str arrives with a≥DEPTH;
  - str and erase are asserted together.
- Rejected requests leave the array and FSM unchanged.
- str and erase together in IDLE: erase wins (if wp=0) and err pulses for the dropped str.
- str and ld together in IDLE, same address: read-before-write. d returns the old word; the new word is committed later.
- Array is not reset (non-volatile model); contents are unknown until written or erased.
- Reset mid-PROG: program aborts and the location is unmodified. Reset mid-ERASE: locations already erased stay erased, the rest are untouched.

## Timing
- Reset values: d=0, d_vld=0, busy=0, err=0, FSM=IDLE, counter=0.
- Read latency is 1 cycle: ld sampled at edge k gives d/d_vld valid after edge k.
- d holds its last value when d_vld=0.
- Program: str accepted at edge k → busy=1 after edges k..k+WR_CYCLES-1. Commit happens at edge k+WR_CYCLES, and busy=0 after it. A ld sampled at edge k+WR_CYCLES+1 or later returns the new data.
- Erase: accepted at edge k → busy=1 for DEPTH cycles; busy=0 after edge k+DEPTH.
- A new str is accepted on the first edge where busy=0 (back-to-back programs with no dead cycle).
- busy is a registered output derived from the FSM state, so there is no combinational path from inputs.
- wp is sampled only at request acceptance. Changing wp during PROG/ERASE does not abort the operation.

## Structure
- Shared package eeprom_pkg holds:
  - the FSM state typedef;
  - the ERASED_WORD constant (all-ones, width DATA_W);
  - a counter-width helper based on $clog2(max(WR_CYCLES, DEPTH)).
- One sub-module, eeprom_array: DEPTH×DATA_W storage with one synchronous write port and one synchronous read port, no reset. The controller FSM, counter, error logic and output registers live in eeprom_param.

## Test plan
- Write 1..16 to addresses 0..15 (default params), waiting for busy=0 each time, then ld all addresses → d=i+1 at address i, busy high exactly 4 cycles per write.
- str a=3, d_in=0xA5 while busy from a prior write → err pulses once, and a later read of addr 3 returns its previous value.
- wp=1, str a=5, d_in=0x1234 → err pulse, busy stays 0; erase with wp=1 → err pulse, no change.
- erase with wp=0 → busy high 16 cycles, then every address reads 0xFFFFFFFF.
- str+ld same cycle at a=7 (old 0x7, d_in 0x77) → d=0x7 next cycle; ld after busy drops → 0x77.
- Deassert rst_n two cycles into a program of a=2 → busy/d_vld/err go to 0 immediately, and addr 2 keeps its old value. Repeat with DATA_W=8, DEPTH=12: ld a=13 → d=0, d_vld=1, err=1.

Source files
------------

// File: rtl/eeprom_pkg.sv
// Shared types and constants for the parametrised EEPROM model.
package eeprom_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PROG,
    ERASE
  } state_e;

  // Widest supported word; modules slice the low DATA_W bits.
  localparam int MAX_DATA_W = 1024;
  localparam logic [MAX_DATA_W-1:0] ERASED_WORD = '1;

  // One counter serves as both program-delay down-counter and erase address index.
  function automatic int cnt_width(input int wr_cycles, input int depth);
    int m;
    m = (wr_cycles > depth) ? wr_cycles : depth;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/eeprom_array.sv
// DEPTH x DATA_W storage: one synchronous write port, one registered read port, no reset.
module eeprom_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              c,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              re,
  input  logic [ADDR_W-1:0] ra,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // A read and a write to the same word on one edge returns the old word.
  always_ff @(posedge c) begin
    if (we) mem_q[wa] <= wd;
    if (re) rdata_q <= mem_q[ra];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/eeprom_param.sv
// EEPROM controller: multi-cycle program, bulk erase, write protect, registered reads.
module eeprom_param
  import eeprom_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int WR_CYCLES = 4
) (
  input  logic              c,
  input  logic              rst_n,
  input  logic              str,
  input  logic              ld,
  input  logic [ADDR_W-1:0] a,
  input  logic [DATA_W-1:0] d_in,
  input  logic              wp,
  input  logic              erase,
  output logic [DATA_W-1:0] d,
  output logic              d_vld,
  output logic              busy,
  output logic              err
);

  localparam int                CNT_W      = cnt_width(WR_CYCLES, DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_L    = (ADDR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0]  PROG_INIT  = CNT_W'(WR_CYCLES - 1);
  localparam logic [CNT_W-1:0]  ERASE_LAST = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              d_vld_q, d_vld_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              zero_q, zero_d;

  logic              a_ok, idle, we, re;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd, rdata;

  assign a_ok = {1'b0, a} < DEPTH_L;
  assign idle = (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we      = 1'b0;
    wa      = addr_q;
    wd      = data_q;
    case (state_q)
      IDLE: begin
        if (erase && !wp) begin
          state_d = ERASE;
          cnt_d   = '0;
        end else if (str && !wp && a_ok) begin
          state_d = PROG;
          cnt_d   = PROG_INIT;
          addr_d  = a;
          data_d  = d_in;
        end
      end
      PROG: begin
        if (cnt_q == '0) begin
          we      = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ERASE: begin
        we = 1'b1;
        wa = cnt_q[ADDR_W-1:0];
        wd = ERASED_WORD[DATA_W-1:0];
        if (cnt_q == ERASE_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Any rejected store/erase, and any out-of-range load, pulses err.
    err_d   = ((str || erase) && (!idle || wp)) || (str && !a_ok) ||
              (str && erase) || (ld && !a_ok);
    busy_d  = (state_d != IDLE);
    d_vld_d = ld;
    re      = ld && a_ok;
    zero_d  = ld ? !a_ok : zero_q;
  end

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      d_vld_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_vld_q <= d_vld_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      zero_q  <= zero_d;
    end
  end

  always_ff @(posedge c) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  eeprom_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .c     (c),
    .we    (we),
    .wa    (wa),
    .wd    (wd),
    .re    (re),
    .ra    (a),
    .rdata (rdata)
  );

  // zero_q masks the read register after reset and for out-of-range loads.
  assign d     = zero_q ? '0 : rdata;
  assign d_vld = d_vld_q;
  assign busy  = busy_q;
  assign err   = err_q;

endmodule

// File: tb/tb_eeprom_param.sv
// Scoreboard bench for eeprom_param: default 32x16 instance plus an 8-bit x 12-word instance.
module tb_eeprom_param;

  logic c = 1'b0;
  always #5 c = ~c;

  logic        rst_n;
  logic        str, ld, wp, erase;
  logic [3:0]  a;
  logic [31:0] d_in, d;
  logic        d_vld, busy, err;

  logic        str2, ld2, wp2, erase2;
  logic [3:0]  a2;
  logic [7:0]  din2, d2;
  logic        d_vld2, busy2, err2;

  eeprom_param u_dut (
    .c(c), .rst_n(rst_n), .str(str), .ld(ld), .a(a), .d_in(d_in), .wp(wp),
    .erase(erase), .d(d), .d_vld(d_vld), .busy(busy), .err(err)
  );

  eeprom_param #(.DATA_W(8), .DEPTH(12)) u_dut2 (
    .c(c), .rst_n(rst_n), .str(str2), .ld(ld2), .a(a2), .d_in(din2), .wp(wp2),
    .erase(erase2), .d(d2), .d_vld(d_vld2), .busy(busy2), .err(err2)
  );

  int total = 0;
  int passed = 0;
  logic [31:0] q1[$];
  logic [31:0] q2[$];
  int e1 = 0;
  int e2 = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Monitors: pop expected read data on d_vld, consume expected err pulses.
  always @(negedge c) begin
    if (d_vld) begin
      chk("vld1_expected", q1.size() != 0, 1'b1);
      if (q1.size() != 0) chk("rd1", d, q1.pop_front());
    end
    if (err) begin
      chk("err1_expected", e1 > 0, 1'b1);
      if (e1 > 0) e1--;
    end
  end

  always @(negedge c) begin
    if (d_vld2) begin
      chk("vld2_expected", q2.size() != 0, 1'b1);
      if (q2.size() != 0) chk("rd2", {24'd0, d2}, q2.pop_front());
    end
    if (err2) begin
      chk("err2_expected", e2 > 0, 1'b1);
      if (e2 > 0) e2--;
    end
  end

  task automatic step();
    @(posedge c);
    #1;
  endtask

  task automatic ld1(input logic [3:0] addr, input logic [31:0] exp, input bit e);
    ld = 1'b1; a = addr; q1.push_back(exp);
    if (e) e1++;
    step();
    ld = 1'b0;
  endtask

  task automatic issue1(input logic [3:0] addr, input logic [31:0] data, input bit e);
    str = 1'b1; a = addr; d_in = data;
    if (e) e1++;
    step();
    str = 1'b0;
  endtask

  task automatic wait1(output int n);
    n = 0;
    while (busy && n < 100) begin n++; step(); end
    if (n >= 100) chk("busy1_timeout", busy, 1'b0);
  endtask

  task automatic store1(input logic [3:0] addr, input logic [31:0] data);
    int n;
    issue1(addr, data, 1'b0);
    wait1(n);
    chk($sformatf("prog_busy_len_a%0d", addr), n, 4);
  endtask

  task automatic ld2t(input logic [3:0] addr, input logic [7:0] exp, input bit e);
    ld2 = 1'b1; a2 = addr; q2.push_back({24'd0, exp});
    if (e) e2++;
    step();
    ld2 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst_n = 1'b0; str = 0; ld = 0; wp = 0; erase = 0; a = 0; d_in = 0;
    str2 = 0; ld2 = 0; wp2 = 0; erase2 = 0; a2 = 0; din2 = 0;
    repeat (3) @(posedge c);
    #1;
    chk("rst_d", d, 32'd0);
    chk("rst_d_vld", d_vld, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_d2", {24'd0, d2}, 32'd0);
    chk("rst_busy2", busy2, 1'b0);
    rst_n = 1'b1;
    step();

    // Fill and read back.
    for (int i = 0; i < 16; i++) store1(4'(i), 32'(i + 1));
    for (int i = 0; i < 16; i++) ld1(4'(i), 32'(i + 1), 1'b0);

    // Store while busy is rejected.
    issue1(4'd4, 32'h44, 1'b0);
    issue1(4'd3, 32'hA5, 1'b1);
    wait1(n);
    ld1(4'd3, 32'd4, 1'b0);
    ld1(4'd4, 32'h44, 1'b0);

    // Write protect blocks store and erase.
    wp = 1'b1;
    issue1(4'd5, 32'h1234, 1'b1);
    chk("wp_str_busy", busy, 1'b0);
    erase = 1'b1; e1++;
    step();
    erase = 1'b0;
    chk("wp_erase_busy", busy, 1'b0);
    wp = 1'b0;
    ld1(4'd5, 32'd6, 1'b0);

    // Bulk erase.
    erase = 1'b1;
    step();
    erase = 1'b0;
    wait1(n);
    chk("erase_busy_len", n, 16);
    for (int i = 0; i < 16; i++) ld1(4'(i), 32'hFFFF_FFFF, 1'b0);

    // Read-before-write and exact commit edge.
    store1(4'd7, 32'h7);
    str = 1'b1; ld = 1'b1; a = 4'd7; d_in = 32'h77; q1.push_back(32'h7);
    step();
    str = 1'b0; ld = 1'b0;
    for (int i = 0; i < 4; i++) ld1(4'd7, 32'h7, 1'b0);
    chk("commit_busy_low", busy, 1'b0);
    ld1(4'd7, 32'h77, 1'b0);
    step();
    step();
    chk("d_hold", d, 32'h77);
    chk("d_vld_low", d_vld, 1'b0);

    // str+erase together: erase wins, str flagged.
    str = 1'b1; erase = 1'b1; a = 4'd0; d_in = 32'h55; e1++;
    step();
    str = 1'b0; erase = 1'b0;
    wait1(n);
    chk("str_erase_busy_len", n, 16);
    ld1(4'd0, 32'hFFFF_FFFF, 1'b0);
    ld1(4'd7, 32'hFFFF_FFFF, 1'b0);

    // Reset two cycles into a program.
    store1(4'd2, 32'h2222);
    issue1(4'd2, 32'hDEAD, 1'b0);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_d_vld", d_vld, 1'b0);
    chk("rstmid_err", err, 1'b0);
    chk("rstmid_d", d, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    repeat (6) step();
    chk("rstmid_idle", busy, 1'b0);
    ld1(4'd2, 32'h2222, 1'b0);

    // Small instance: non-power-of-two depth.
    str2 = 1'b1; a2 = 4'd11; din2 = 8'hAB;
    step();
    str2 = 1'b0;
    n = 0;
    while (busy2 && n < 100) begin n++; step(); end
    chk("prog2_busy_len", n, 4);
    ld2t(4'd11, 8'hAB, 1'b0);
    ld2t(4'd13, 8'h00, 1'b1);
    chk("oor_d_hold", {24'd0, d2}, 32'd0);
    ld2t(4'd12, 8'h00, 1'b1);
    ld2t(4'd11, 8'hAB, 1'b0);
    str2 = 1'b1; a2 = 4'd12; din2 = 8'h5A; e2++;
    step();
    str2 = 1'b0;
    chk("oor_str_busy2", busy2, 1'b0);

    repeat (3) step();
    chk("q1_drained", q1.size(), 0);
    chk("e1_drained", e1, 0);
    chk("q2_drained", q2.size(), 0);
    chk("e2_drained", e2, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
